// File: rtl/reg_bus_arbiter_if.sv
// Register-file write bus bundle: requester side (req/addr/data/ack) plus the
// shared write bus driven by the arbiter. The arbiter uses the slave modport,
// requesters and benches use the master modport.
interface reg_bus_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8
);
  localparam int ID_BITS = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           ack;
  logic                         busy;
  logic [ID_BITS-1:0]           grant_id;
  logic                         bus_w_en;
  logic [ADDR_BITS-1:0]         bus_addr;
  logic [DATA_BITS-1:0]         bus_data;

  modport slave (
    input  req, req_addr, req_data,
    output ack, busy, grant_id, bus_w_en, bus_addr, bus_data
  );

  modport master (
    output req, req_addr, req_data,
    input  ack, busy, grant_id, bus_w_en, bus_addr, bus_data
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Shares the register-file write bus between several requesters. One winner
// is granted at a time, its address/data are latched, bus_w_en is held for
// WR_CYCLES cycles and the winner gets a one-cycle ack. Arbitration is either
// requester 0 on top with round-robin among the rest, or pure round-robin.
module reg_bus_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8,
  parameter int WR_CYCLES = 1,
  parameter int PRIO_REQ0 = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sleep,
  reg_bus_arbiter_if.slave bus
);
  localparam int ID_BITS  = $clog2(NUM_REQ);
  localparam int CNT_BITS = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t               state, state_d;
  logic [CNT_BITS-1:0]  count, count_d;
  logic [ID_BITS-1:0]   grant_q, grant_d;
  logic [ID_BITS-1:0]   last_q, last_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [ID_BITS-1:0]   winner;
  logic                 win_valid;
  logic [NUM_REQ-1:0]   ack_vec;

  // Pick the next requester to serve, scanning upward from the one after the last served
  always_comb begin
    int start;
    int cand_i;
    logic [ID_BITS-1:0] cand;
    winner    = '0;
    win_valid = 1'b0;
    start     = 0;
    cand_i    = 0;
    cand      = '0;
    if (PRIO_REQ0 != 0) begin
      if (bus.req[0]) begin
        winner    = '0;
        win_valid = 1'b1;
      end else begin
        start = int'(last_q) + 1;
        if (start > NUM_REQ - 1) start = 1;
        for (int k = 0; k < NUM_REQ - 1; k++) begin
          cand_i = start + k;
          if (cand_i > NUM_REQ - 1) cand_i = cand_i - (NUM_REQ - 1);
          cand = ID_BITS'(cand_i);
          if (!win_valid && bus.req[cand]) begin
            winner    = cand;
            win_valid = 1'b1;
          end
        end
      end
    end else begin
      start = int'(last_q) + 1;
      if (start >= NUM_REQ) start = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        cand_i = start + k;
        if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
        cand = ID_BITS'(cand_i);
        if (!win_valid && bus.req[cand]) begin
          winner    = cand;
          win_valid = 1'b1;
        end
      end
    end
  end

  // Next-state logic: grant in IDLE, count down the strobe in WRITE, retire in ACK
  always_comb begin
    state_d = state;
    count_d = count;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state)
      IDLE: begin
        if (!sleep && win_valid) begin
          state_d = WRITE;
          count_d = CNT_BITS'(WR_CYCLES - 1);
          grant_d = winner;
          addr_d  = bus.req_addr[int'(winner)*ADDR_BITS +: ADDR_BITS];
          data_d  = bus.req_data[int'(winner)*DATA_BITS +: DATA_BITS];
        end
      end
      WRITE: begin
        if (count == '0) state_d = ACK;
        else             count_d = count - CNT_BITS'(1);
      end
      ACK: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched write registers; reset abandons any write in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      grant_q <= '0;
      last_q  <= ID_BITS'(NUM_REQ - 1);
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_d;
      count   <= count_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Completion pulse goes only to the requester that owned the write
  always_comb begin
    ack_vec = '0;
    if (state == ACK) ack_vec[grant_q] = 1'b1;
  end

  assign bus.ack      = ack_vec;
  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = grant_q;
  assign bus.bus_w_en = (state == WRITE);
  assign bus.bus_addr = addr_q;
  assign bus.bus_data = data_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter. Three instances cover the configurations of
// interest: A (2 req, 1-cycle strobe, req0 priority), B (3 req, pure
// round-robin), C (2 req, 3-cycle strobe). Expected writes are queued when
// stimulus is issued; a negedge monitor pops and checks every write it sees.
module tb_reg_bus_arbiter;
  typedef struct packed {
    logic [1:0] dut;
    logic [1:0] id;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  logic sleep;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  reg_bus_arbiter_if #(.NUM_REQ(2), .ADDR_BITS(4), .DATA_BITS(8)) if_a ();
  reg_bus_arbiter_if #(.NUM_REQ(3), .ADDR_BITS(4), .DATA_BITS(8)) if_b ();
  reg_bus_arbiter_if #(.NUM_REQ(2), .ADDR_BITS(4), .DATA_BITS(8)) if_c ();

  reg_bus_arbiter #(.NUM_REQ(2), .ADDR_BITS(4), .DATA_BITS(8), .WR_CYCLES(1), .PRIO_REQ0(1))
    dut_a (.clk(clk), .reset(rst), .sleep(sleep), .bus(if_a));
  reg_bus_arbiter #(.NUM_REQ(3), .ADDR_BITS(4), .DATA_BITS(8), .WR_CYCLES(1), .PRIO_REQ0(0))
    dut_b (.clk(clk), .reset(rst), .sleep(sleep), .bus(if_b));
  reg_bus_arbiter #(.NUM_REQ(2), .ADDR_BITS(4), .DATA_BITS(8), .WR_CYCLES(3), .PRIO_REQ0(1))
    dut_c (.clk(clk), .reset(rst), .sleep(sleep), .bus(if_c));

  logic       s_wen  [3];
  logic       s_busy [3];
  logic [2:0] s_ack  [3];
  logic [1:0] s_gid  [3];
  logic [3:0] s_addr [3];
  logic [7:0] s_data [3];

  assign s_wen[0]  = if_a.bus_w_en;
  assign s_wen[1]  = if_b.bus_w_en;
  assign s_wen[2]  = if_c.bus_w_en;
  assign s_busy[0] = if_a.busy;
  assign s_busy[1] = if_b.busy;
  assign s_busy[2] = if_c.busy;
  assign s_ack[0]  = {1'b0, if_a.ack};
  assign s_ack[1]  = if_b.ack;
  assign s_ack[2]  = {1'b0, if_c.ack};
  assign s_gid[0]  = {1'b0, if_a.grant_id};
  assign s_gid[1]  = if_b.grant_id;
  assign s_gid[2]  = {1'b0, if_c.grant_id};
  assign s_addr[0] = if_a.bus_addr;
  assign s_addr[1] = if_b.bus_addr;
  assign s_addr[2] = if_c.bus_addr;
  assign s_data[0] = if_a.bus_data;
  assign s_data[1] = if_b.bus_data;
  assign s_data[2] = if_c.bus_data;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int wrCycles(input int d);
    return (d == 2) ? 3 : 1;
  endfunction

  task automatic pushExp(input int d, input int id, input logic [3:0] a, input logic [7:0] v);
    exp_t e;
    e.dut  = 2'(d);
    e.id   = 2'(id);
    e.addr = a;
    e.data = v;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input int d, input int id, input logic [3:0] a, input logic [7:0] v);
    case (d)
      0: begin
        if_a.req_addr[id*4 +: 4] = a;
        if_a.req_data[id*8 +: 8] = v;
        if_a.req[id] = 1'b1;
      end
      1: begin
        if_b.req_addr[id*4 +: 4] = a;
        if_b.req_data[id*8 +: 8] = v;
        if_b.req[id] = 1'b1;
      end
      default: begin
        if_c.req_addr[id*4 +: 4] = a;
        if_c.req_data[id*8 +: 8] = v;
        if_c.req[id] = 1'b1;
      end
    endcase
  endtask

  task automatic dropReq(input int d, input int id);
    case (d)
      0:       if_a.req[id] = 1'b0;
      1:       if_b.req[id] = 1'b0;
      default: if_c.req[id] = 1'b0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitAck(input int d, input int budget, output logic [2:0] seen);
    seen = '0;
    for (int i = 0; i < budget && seen == 3'b000; i++) begin
      @(negedge clk);
      seen = s_ack[d];
    end
    if (seen == 3'b000) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout dut=%0d: got no ack in %0d cycles, required one", d, budget);
    end
  endtask

  // Monitor state, one slot per instance
  logic       prev_wen   [3];
  logic       active     [3];
  logic       ack_follow [3];
  int         width      [3];
  logic [1:0] cur_id     [3];
  logic [3:0] cur_addr   [3];
  logic [7:0] cur_data   [3];

  task automatic monitorStep(input int d);
    exp_t e;
    logic [2:0] one_hot;
    if (s_wen[d] && !prev_wen[d]) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        active[d] = 1'b0;
        $display("[TB] FAIL unexpected_write dut=%0d: got addr 0x%0h data 0x%0h, required no write",
                 d, s_addr[d], s_data[d]);
      end else begin
        e = sb_q.pop_front();
        checkOutput("write_content", {2'(d), s_gid[d], s_addr[d], s_data[d]}, e);
        cur_id[d]   = e.id;
        cur_addr[d] = e.addr;
        cur_data[d] = e.data;
        width[d]    = 1;
        active[d]   = 1'b1;
      end
    end else if (s_wen[d] && prev_wen[d]) begin
      width[d]++;
      if (active[d]) checkOutput("write_hold", {s_addr[d], s_data[d]}, {cur_addr[d], cur_data[d]});
    end else if (!s_wen[d] && prev_wen[d]) begin
      if (active[d]) begin
        checkOutput("write_width", width[d], wrCycles(d));
        one_hot = 3'b001 << cur_id[d];
        checkOutput("ack_onehot", s_ack[d], one_hot);
        ack_follow[d] = 1'b1;
      end
      active[d] = 1'b0;
    end else if (ack_follow[d]) begin
      checkOutput("ack_one_cycle", s_ack[d], 0);
      ack_follow[d] = 1'b0;
    end else begin
      checkOutput("ack_idle", s_ack[d], 0);
    end
    prev_wen[d] = s_wen[d];
  endtask

  // Scoreboard monitor: samples on falling edges, forgets in-flight writes on reset
  initial begin
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        for (int d = 0; d < 3; d++) begin
          prev_wen[d]   = 1'b0;
          active[d]     = 1'b0;
          ack_follow[d] = 1'b0;
          width[d]      = 0;
        end
      end else begin
        for (int d = 0; d < 3; d++) monitorStep(d);
      end
    end
  end

  // Hard stop in case something upstream never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus and cycle-exact timing checks
  initial begin
    logic [2:0] seen;
    rst   = 1'b1;
    sleep = 1'b0;
    if_a.req = '0; if_a.req_addr = '0; if_a.req_data = '0;
    if_b.req = '0; if_b.req_addr = '0; if_b.req_data = '0;
    if_c.req = '0; if_c.req_addr = '0; if_c.req_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset values");
    @(negedge clk);
    checkOutput("rst_wen",  s_wen[0], 0);
    checkOutput("rst_ack",  s_ack[0], 0);
    checkOutput("rst_busy", s_busy[0], 0);
    checkOutput("rst_gid",  s_gid[1], 0);
    checkOutput("rst_addr", s_addr[0], 0);
    checkOutput("rst_data", s_data[2], 0);

    $display("[TB] single write");
    tick();
    pushExp(0, 0, 4'h1, 8'hAA);
    applyStimulus(0, 0, 4'h1, 8'hAA);
    @(negedge clk);
    checkOutput("t1_not_yet", s_wen[0], 0);
    @(negedge clk);
    checkOutput("t1_wen", s_wen[0], 1);
    checkOutput("t1_busy", s_busy[0], 1);
    @(negedge clk);
    checkOutput("t1_ack", s_ack[0], 3'b001);
    checkOutput("t1_wen_low", s_wen[0], 0);
    tick();
    dropReq(0, 0);
    @(negedge clk);
    checkOutput("t1_busy_after", s_busy[0], 0);
    repeat (2) tick();

    $display("[TB] fixed priority contention");
    pushExp(0, 0, 4'h7, 8'h55);
    pushExp(0, 1, 4'h2, 8'h33);
    applyStimulus(0, 0, 4'h7, 8'h55);
    applyStimulus(0, 1, 4'h2, 8'h33);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2_first_gid", s_gid[0], 0);
    @(negedge clk);
    checkOutput("t2_first_ack", s_ack[0], 3'b001);
    tick();
    dropReq(0, 0);
    @(negedge clk);
    checkOutput("t2_gap", s_wen[0], 0);
    @(negedge clk);
    checkOutput("t2_second_start", s_wen[0], 1);
    checkOutput("t2_second_gid", s_gid[0], 1);
    @(negedge clk);
    checkOutput("t2_second_ack", s_ack[0], 3'b010);
    tick();
    dropReq(0, 1);
    repeat (2) tick();

    $display("[TB] round robin over three");
    for (int i = 0; i < 6; i++) pushExp(1, i % 3, 4'(4'h8 + (i % 3)), 8'(8'hB0 + (i % 3)));
    for (int id = 0; id < 3; id++) applyStimulus(1, id, 4'(4'h8 + id), 8'(8'hB0 + id));
    for (int i = 0; i < 6; i++) begin
      waitAck(1, 10, seen);
      checkOutput("t3_order", seen, 3'(3'b001 << (i % 3)));
    end
    tick();
    for (int id = 0; id < 3; id++) dropReq(1, id);
    repeat (3) tick();

    $display("[TB] three-cycle strobe");
    pushExp(2, 0, 4'h5, 8'hC3);
    applyStimulus(2, 0, 4'h5, 8'hC3);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_wen", s_wen[2], 1);
    tick();
    if_c.req_data[7:0] = 8'h99;
    waitAck(2, 10, seen);
    checkOutput("t4_ack", seen, 3'b001);
    tick();
    dropReq(2, 0);
    repeat (2) tick();

    $display("[TB] sleep");
    pushExp(0, 0, 4'h3, 8'h10);
    pushExp(0, 1, 4'h4, 8'h20);
    applyStimulus(0, 0, 4'h3, 8'h10);
    applyStimulus(0, 1, 4'h4, 8'h20);
    tick();
    sleep = 1'b1;
    @(negedge clk);
    checkOutput("t5_write_in_sleep", s_wen[0], 1);
    @(negedge clk);
    checkOutput("t5_ack_in_sleep", s_ack[0], 3'b001);
    tick();
    dropReq(0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t5_blocked", {s_wen[0], s_busy[0]}, 0);
    end
    tick();
    sleep = 1'b0;
    @(negedge clk);
    checkOutput("t5_wake_same_cycle", s_wen[0], 0);
    @(negedge clk);
    checkOutput("t5_regrant", s_wen[0], 1);
    checkOutput("t5_regrant_gid", s_gid[0], 1);
    @(negedge clk);
    checkOutput("t5_ack1", s_ack[0], 3'b010);
    tick();
    dropReq(0, 1);
    repeat (2) tick();

    $display("[TB] reset during write");
    pushExp(2, 0, 4'h6, 8'h77);
    pushExp(2, 0, 4'h6, 8'h77);
    applyStimulus(2, 0, 4'h6, 8'h77);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_writing", s_wen[2], 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_wen_drop", s_wen[2], 0);
    checkOutput("t6_ack_drop", s_ack[2], 0);
    checkOutput("t6_busy_drop", s_busy[2], 0);
    #1 rst = 1'b0;
    waitAck(2, 12, seen);
    checkOutput("t6_reack", seen, 3'b001);
    tick();
    dropReq(2, 0);
    repeat (8) tick();

    checkOutput("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
